// File: rtl/rr_pkg.sv
// Shared types and constants for the log-channel round-robin arbiter.
//   log_chan_id_t : channel index for the default five-channel configuration
//   arb_state_e   : arbiter FSM states
//   CHAN_*        : default channel assignments of the per-interface log streams
//   wrap_inc      : increment modulo n, used for round-robin pointer math
package rr_pkg;

    localparam int LOG_NUM_CHAN  = 5;
    localparam int LOG_CHAN_ID_W = $clog2(LOG_NUM_CHAN);

    typedef logic [LOG_CHAN_ID_W-1:0] log_chan_id_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam log_chan_id_t CHAN_SDA  = log_chan_id_t'(0);
    localparam log_chan_id_t CHAN_OCL  = log_chan_id_t'(1);
    localparam log_chan_id_t CHAN_BAR1 = log_chan_id_t'(2);
    localparam log_chan_id_t CHAN_PCIM = log_chan_id_t'(3);
    localparam log_chan_id_t CHAN_PCIS = log_chan_id_t'(4);

    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/rr_log_chan_arbiter_pick.sv
// Combinational rotate-priority pick.
//   req    : request vector, one bit per requester
//   ptr    : highest-priority index; search runs upward from here modulo N
//   gnt    : one-hot grant (all zero when no request)
//   gnt_id : index of the granted requester (0 when no request)
module rr_rr_pick
    import rr_pkg::*;
#(
    parameter  int N  = 5,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id
);

    int   idx;
    logic found;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = int'(ptr);
        for (int i = 0; i < N; i++) begin
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = IW'(idx);
            end
            idx = wrap_inc(idx, N);
        end
    end

endmodule

// File: rtl/rr_log_chan_arbiter.sv
// Packet-granular round-robin arbiter sharing one log sink between NUM_CHAN
// log channels, with a single registered output stage tagging each beat with
// its source channel.
//   clk, sync_rst          : clock, synchronous active-high reset
//   enable                 : 1 arbitrate; 0 finish the current packet, then stop
//   in_valid/in_last       : per-channel beat valid / last beat of packet
//   in_data                : per-channel beats, chan i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_ready               : per-channel ready, one-hot or zero
//   out_valid/out_last     : registered output beat valid / last
//   out_data/out_chan      : registered output beat and its source channel
//   out_ready              : sink ready
//   idle                   : no packet granted and output register empty
//   overlong_err           : sticky, a packet ran past MAX_PKT beats
//
// Handshake: a beat moves on any interface in the cycle where valid and ready
// are both high at the rising edge; valid never depends on ready, and a
// producer holds its beat stable until it is taken.
module rr_log_chan_arbiter
    import rr_pkg::*;
#(
    parameter  int NUM_CHAN   = 5,
    parameter  int DATA_WIDTH = 512,
    parameter  int MAX_PKT    = 16,
    localparam int ID_W       = $clog2(NUM_CHAN)
) (
    input  logic                           clk,
    input  logic                           sync_rst,
    input  logic                           enable,
    input  logic [NUM_CHAN-1:0]            in_valid,
    input  logic [NUM_CHAN-1:0]            in_last,
    input  logic [NUM_CHAN*DATA_WIDTH-1:0] in_data,
    output logic [NUM_CHAN-1:0]            in_ready,
    output logic                           out_valid,
    output logic                           out_last,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [ID_W-1:0]                out_chan,
    input  logic                           out_ready,
    output logic                           idle,
    output logic                           overlong_err
);

    localparam int CNT_W = $clog2(MAX_PKT + 1);

    arb_state_e            state_q, state_d;
    logic [ID_W-1:0]       gnt_id_q, gnt_id_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [ID_W-1:0]       out_chan_q, out_chan_d;
    logic                  overlong_q, overlong_d;

    logic [NUM_CHAN-1:0]   pick_req, pick_gnt;
    logic [ID_W-1:0]       pick_ptr, pick_id, next_ptr;
    logic                  pick_any;
    logic                  slot_ready, beat_take, take_last;

    assign next_ptr = ID_W'(wrap_inc(int'(gnt_id_q), NUM_CHAN));

    // While granted, the pick pre-computes the successor for a zero-bubble
    // hand-over. The current owner is masked: its in_valid belongs to the
    // last beat being taken, not to a new packet.
    assign pick_req = (state_q == GRANT) ? (in_valid & ~(NUM_CHAN'(1) << gnt_id_q)) : in_valid;
    assign pick_ptr = (state_q == GRANT) ? next_ptr : rr_ptr_q;
    assign pick_any = |pick_gnt;

    rr_rr_pick #(.N(NUM_CHAN)) u_pick (
        .req    (pick_req),
        .ptr    (pick_ptr),
        .gnt    (pick_gnt),
        .gnt_id (pick_id)
    );

    // The output register can accept a beat when empty or draining this cycle.
    assign slot_ready = (state_q == GRANT) && (!out_valid_q || out_ready);
    assign beat_take  = slot_ready && in_valid[gnt_id_q];
    assign take_last  = beat_take && in_last[gnt_id_q];
    assign in_ready   = slot_ready ? (NUM_CHAN'(1) << gnt_id_q) : '0;

    always_comb begin
        state_d     = state_q;
        gnt_id_d    = gnt_id_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        overlong_d  = overlong_q;

        case (state_q)
            IDLE: begin
                if (enable && pick_any) begin
                    state_d  = GRANT;
                    gnt_id_d = pick_id;
                end
            end
            GRANT: begin
                if (take_last) begin
                    rr_ptr_d = next_ptr;
                    if (enable && pick_any) begin
                        gnt_id_d = pick_id;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (beat_take) begin
            out_valid_d = 1'b1;
            out_last_d  = in_last[gnt_id_q];
            out_data_d  = in_data[int'(gnt_id_q)*DATA_WIDTH +: DATA_WIDTH];
            out_chan_d  = gnt_id_q;
            if (in_last[gnt_id_q]) begin
                beat_cnt_d = '0;
            end else begin
                if (beat_cnt_q == CNT_W'(MAX_PKT - 1)) begin
                    overlong_d = 1'b1;
                end
                // Saturate so an endless packet cannot wrap the counter.
                if (beat_cnt_q != CNT_W'(MAX_PKT)) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q     <= IDLE;
            gnt_id_q    <= '0;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            overlong_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_id_q    <= gnt_id_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            overlong_q  <= overlong_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_last     = out_last_q;
    assign out_data     = out_data_q;
    assign out_chan     = out_chan_q;
    assign overlong_err = overlong_q;
    assign idle         = (state_q == IDLE) && !out_valid_q;

endmodule

// File: tb/tb_rr_log_chan_arbiter.sv
// Self-checking bench for rr_log_chan_arbiter: directed scenarios plus
// randomized packet traffic scored against a packet-level round-robin model.
module tb_rr_log_chan_arbiter;
  import rr_pkg::*;

  localparam int NC   = 5;
  localparam int DW   = 32;
  localparam int MAXP = 16;
  localparam int IDW  = $clog2(NC);
  localparam int EW   = 1 + IDW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             sync_rst;
  logic             enable;
  logic [NC-1:0]    in_valid, in_last, in_ready;
  logic [NC*DW-1:0] in_data;
  logic             out_valid, out_last, out_ready, idle, overlong_err;
  logic [DW-1:0]    out_data;
  logic [IDW-1:0]   out_chan;

  rr_log_chan_arbiter #(.NUM_CHAN(NC), .DATA_WIDTH(DW), .MAX_PKT(MAXP)) dut (
    .clk          (clk),
    .sync_rst     (sync_rst),
    .enable       (enable),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_last     (out_last),
    .out_data     (out_data),
    .out_chan     (out_chan),
    .out_ready    (out_ready),
    .idle         (idle),
    .overlong_err (overlong_err)
  );

  // ---------------- bench state ----------------
  logic [DW:0]   chan_beats [NC][$];   // {last, data} still to be offered per channel
  logic [DW:0]   model_beats[NC][$];   // copy consumed by the reference model
  bit            mid_pkt[NC];
  logic [EW-1:0] exp_q[$];             // expected output beats {last, chan, data}
  logic [EW-1:0] exp_e;
  int            bubble_pct;
  logic          ready_drv;

  logic          ob_valid, ob_last, ob_idle, ob_ovl;
  logic [DW-1:0] ob_data;
  logic [IDW-1:0] ob_chan;
  logic [NC-1:0] ob_ready;
  int            took_ch;
  logic [DW-1:0] took_data;
  logic          took_last;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    sync_rst   = 1'b1;
    enable     = 1'b1;
    in_valid   = '0;
    in_last    = '0;
    in_data    = '0;
    out_ready  = 1'b0;
    ready_drv  = 1'b1;
    bubble_pct = 0;
    for (int i = 0; i < NC; i++) begin
      chan_beats[i].delete();
      model_beats[i].delete();
      mid_pkt[i] = 1'b0;
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 sync_rst = 1'b0;
  endtask

  task automatic add_pkt(input int ch, input int len, input logic [DW-1:0] base,
                         input bit rnd, input bit with_last, input bit to_model);
    logic [DW:0] b;
    for (int k = 0; k < len; k++) begin
      b[DW-1:0] = rnd ? DW'($urandom) : base + DW'(k);
      b[DW]     = with_last && (k == len - 1);
      chan_beats[ch].push_back(b);
      if (to_model) model_beats[ch].push_back(b);
    end
  endtask

  // One clock: drive inputs after the edge, sample at the falling edge, then
  // retire any beat the DUT accepted.
  task automatic step_cycle();
    @(posedge clk);
    #1;
    out_ready = ready_drv;
    for (int i = 0; i < NC; i++) begin
      if (chan_beats[i].size() > 0 && !(mid_pkt[i] && ($urandom_range(99) < 32'(bubble_pct)))) begin
        in_valid[i]          = 1'b1;
        in_last[i]           = chan_beats[i][0][DW];
        in_data[i*DW +: DW]  = chan_beats[i][0][DW-1:0];
      end else begin
        in_valid[i]          = 1'b0;
        in_last[i]           = 1'($urandom);
        in_data[i*DW +: DW]  = DW'($urandom);
      end
    end
    @(negedge clk);
    ob_valid = out_valid;
    ob_last  = out_last;
    ob_data  = out_data;
    ob_chan  = out_chan;
    ob_ready = in_ready;
    ob_idle  = idle;
    ob_ovl   = overlong_err;
    took_ch  = -1;
    for (int i = 0; i < NC; i++) begin
      if (in_valid[i] && in_ready[i]) begin
        took_ch   = i;
        took_data = chan_beats[i][0][DW-1:0];
        took_last = chan_beats[i][0][DW];
        mid_pkt[i] = !chan_beats[i][0][DW];
        void'(chan_beats[i].pop_front());
      end
    end
  endtask

  // Reference model: whole packets, one channel at a time, next channel is the
  // first with pending packets at or after the pointer, pointer = winner + 1.
  task automatic model_run(input int start_ptr);
    int ptr;
    int c;
    logic [DW:0] b;
    ptr = start_ptr;
    while (1) begin
      c = -1;
      for (int k = 0; k < NC; k++) begin
        if (c < 0 && model_beats[(ptr + k) % NC].size() > 0) c = (ptr + k) % NC;
      end
      if (c < 0) break;
      do begin
        b = model_beats[c].pop_front();
        exp_q.push_back({b[DW], IDW'(c), b[DW-1:0]});
      end while (!b[DW] && model_beats[c].size() > 0);
      ptr = (c + 1) % NC;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    sync_rst  = 1'b1;
    enable    = 1'b1;
    in_valid  = NC'($urandom);
    in_last   = '1;
    in_data   = {NC{32'hDEAD_BEEF}};
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0 || out_chan !== '0) begin
      n_errors++;
      $display("FAIL reset_out: valid=%b last=%b data=%h chan=%0d, required all zero", out_valid, out_last, out_data, out_chan);
    end
    n_checks++;
    if (in_ready !== '0 || idle !== 1'b1 || overlong_err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_ctl: in_ready=%b idle=%b overlong=%b, required 0/1/0", in_ready, idle, overlong_err);
    end
    @(posedge clk);
    #1 sync_rst = 1'b0;
    in_valid = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++;
      if (idle !== 1'b1 || in_ready !== '0 || out_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_idle cycle %0d: idle=%b in_ready=%b out_valid=%b, required 1/0/0", c, idle, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_single_pkt();
    int t_first, n_take;
    bit pend;
    logic [DW-1:0] pend_d;
    logic pend_l;
    t_first = -1; n_take = 0; pend = 0; pend_d = '0; pend_l = 0;
    do_reset();
    ready_drv = 1'b1;
    add_pkt(int'(CHAN_OCL), 3, 32'hA1, 0, 1, 1);
    model_run(0);
    for (int cy = 0; cy < 12; cy++) begin
      step_cycle();
      if (pend) begin
        n_checks++;
        if (ob_valid !== 1'b1 || ob_data !== pend_d || ob_last !== pend_l || ob_chan !== IDW'(1)) begin
          n_errors++;
          $display("FAIL single_latency: valid=%b data=%h last=%b chan=%0d, required 1/%h/%b/1", ob_valid, ob_data, ob_last, ob_chan, pend_d, pend_l);
        end
      end
      pend = 0;
      if (ob_valid && ready_drv) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL single_beat: unexpected chan=%0d data=%h, required none", ob_chan, ob_data);
        end else begin
          exp_e = exp_q.pop_front();
          if ({ob_last, ob_chan, ob_data} !== exp_e) begin
            n_errors++;
            $display("FAIL single_beat: got %b/%0d/%h, required %b/%0d/%h", ob_last, ob_chan, ob_data, exp_e[EW-1], exp_e[DW+IDW-1:DW], exp_e[DW-1:0]);
          end
        end
      end
      if (took_ch == 1) begin
        if (t_first < 0) t_first = cy;
        n_checks++;
        if (cy - t_first != n_take) begin
          n_errors++;
          $display("FAIL single_gap: beat %0d taken at offset %0d, required %0d", n_take, cy - t_first, n_take);
        end
        n_take++;
        pend = 1; pend_d = took_data; pend_l = took_last;
      end
    end
    n_checks++;
    if (exp_q.size() != 0 || n_take != 3) begin
      n_errors++;
      $display("FAIL single_done: takes=%0d left=%0d, required 3/0", n_take, exp_q.size());
    end
  endtask

  task automatic test_rr_order();
    int first_t, last_t, n_take, cy;
    first_t = -1; last_t = -1; n_take = 0; cy = 0;
    do_reset();
    ready_drv = 1'b1;
    for (int r = 0; r < 3; r++)
      for (int ch = 0; ch < NC; ch++) add_pkt(ch, 1, DW'(ch * 16 + r), 0, 1, 1);
    model_run(0);
    while ((exp_q.size() > 0) && cy < 60) begin
      step_cycle();
      if (ob_valid && ready_drv) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL rr_order: unexpected chan=%0d data=%h, required none", ob_chan, ob_data);
        end else begin
          exp_e = exp_q.pop_front();
          if ({ob_last, ob_chan, ob_data} !== exp_e) begin
            n_errors++;
            $display("FAIL rr_order: got %b/%0d/%h, required %b/%0d/%h", ob_last, ob_chan, ob_data, exp_e[EW-1], exp_e[DW+IDW-1:DW], exp_e[DW-1:0]);
          end
        end
      end
      if (took_ch >= 0) begin
        if (first_t < 0) first_t = cy;
        last_t = cy;
        n_take++;
      end
      cy++;
    end
    n_checks++;
    if (exp_q.size() != 0 || n_take != 15 || last_t - first_t != 14) begin
      n_errors++;
      $display("FAIL rr_gapless: takes=%0d span=%0d left=%0d, required 15/14/0", n_take, last_t - first_t, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int cy;
    cy = 0;
    do_reset();
    add_pkt(int'(CHAN_SDA), 4, 32'hC0, 0, 1, 1);
    add_pkt(int'(CHAN_BAR1), 2, 32'hE0, 0, 1, 1);
    model_run(0);
    while ((exp_q.size() > 0) && cy < 60) begin
      ready_drv = !(cy >= 3 && cy <= 5);
      step_cycle();
      if (ob_valid && !ready_drv) begin
        n_checks++;
        if (ob_ready !== '0) begin
          n_errors++;
          $display("FAIL bp_stall_ready: in_ready=%b, required 0", ob_ready);
        end
      end
      if (chan_beats[0].size() > 0) begin
        n_checks++;
        if (ob_ready[2] !== 1'b0) begin
          n_errors++;
          $display("FAIL bp_no_preempt: in_ready=%b, required chan2 bit 0", ob_ready);
        end
      end
      if (ob_valid && ready_drv) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL bp_beat: unexpected chan=%0d data=%h, required none", ob_chan, ob_data);
        end else begin
          exp_e = exp_q.pop_front();
          if ({ob_last, ob_chan, ob_data} !== exp_e) begin
            n_errors++;
            $display("FAIL bp_beat: got %b/%0d/%h, required %b/%0d/%h", ob_last, ob_chan, ob_data, exp_e[EW-1], exp_e[DW+IDW-1:DW], exp_e[DW-1:0]);
          end
        end
      end
      cy++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL bp_timeout: %0d beats left, required 0", exp_q.size());
    end
  endtask

  task automatic test_enable_drop();
    int n3;
    n3 = 0;
    do_reset();
    ready_drv = 1'b1;
    add_pkt(int'(CHAN_PCIM), 4, 32'hD0, 0, 1, 1);
    model_run(0);
    add_pkt(int'(CHAN_PCIS), 1, 32'hF0, 0, 1, 0);
    for (int cy = 0; cy < 14; cy++) begin
      step_cycle();
      if (ob_valid && ready_drv) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL en_beat: unexpected chan=%0d data=%h, required none", ob_chan, ob_data);
        end else begin
          exp_e = exp_q.pop_front();
          if ({ob_last, ob_chan, ob_data} !== exp_e) begin
            n_errors++;
            $display("FAIL en_beat: got %b/%0d/%h, required %b/%0d/%h", ob_last, ob_chan, ob_data, exp_e[EW-1], exp_e[DW+IDW-1:DW], exp_e[DW-1:0]);
          end
        end
      end
      if (took_ch == 3) begin
        n3++;
        if (n3 == 2) enable = 1'b0;
      end
    end
    n_checks++;
    if (ob_idle !== 1'b1 || ob_ready !== '0 || exp_q.size() != 0 || chan_beats[4].size() != 1) begin
      n_errors++;
      $display("FAIL en_stop: idle=%b in_ready=%b left=%0d chan4_pending=%0d, required 1/0/0/1", ob_idle, ob_ready, exp_q.size(), chan_beats[4].size());
    end
    enable = 1'b1;
    exp_q.push_back({1'b1, IDW'(4), 32'hF0});
    for (int cy = 0; cy < 10; cy++) begin
      step_cycle();
      if (ob_valid && ready_drv) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL en_resume: unexpected chan=%0d data=%h, required none", ob_chan, ob_data);
        end else begin
          exp_e = exp_q.pop_front();
          if ({ob_last, ob_chan, ob_data} !== exp_e) begin
            n_errors++;
            $display("FAIL en_resume: got %b/%0d/%h, required %b/%0d/%h", ob_last, ob_chan, ob_data, exp_e[EW-1], exp_e[DW+IDW-1:DW], exp_e[DW-1:0]);
          end
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL en_resume_done: %0d beats left, required 0", exp_q.size());
    end
  endtask

  task automatic test_overlong();
    int n_taken, cy;
    bit exp_ovl;
    do_reset();
    ready_drv = 1'b1;
    // Exactly MAX_PKT beats with last on the final one is within budget.
    add_pkt(int'(CHAN_OCL), MAXP, 32'h100, 0, 1, 0);
    for (int c = 0; c < MAXP + 4; c++) step_cycle();
    n_checks++;
    if (ob_ovl !== 1'b0 || chan_beats[1].size() != 0) begin
      n_errors++;
      $display("FAIL ovl_exact: overlong=%b left=%0d, required 0/0", ob_ovl, chan_beats[1].size());
    end
    add_pkt(int'(CHAN_BAR1), 20, 32'h200, 0, 0, 0);
    n_taken = 0; cy = 0;
    while (n_taken < 18 && cy < 60) begin
      step_cycle();
      exp_ovl = (n_taken >= MAXP);
      n_checks++;
      if (ob_ovl !== exp_ovl) begin
        n_errors++;
        $display("FAIL ovl_flag after %0d beats: overlong=%b, required %b", n_taken, ob_ovl, exp_ovl);
      end
      if (n_taken >= 1) begin
        n_checks++;
        if (ob_ready !== NC'(4)) begin
          n_errors++;
          $display("FAIL ovl_hold after %0d beats: in_ready=%b, required 00100", n_taken, ob_ready);
        end
      end
      if (took_ch == 2) n_taken++;
      cy++;
    end
    n_checks++;
    if (n_taken != 18) begin
      n_errors++;
      $display("FAIL ovl_timeout: took %0d beats, required 18", n_taken);
    end
    @(posedge clk);
    #1 sync_rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0 || out_chan !== '0 ||
        in_ready !== '0 || idle !== 1'b1 || overlong_err !== 1'b0) begin
      n_errors++;
      $display("FAIL ovl_reset: valid=%b last=%b data=%h chan=%0d in_ready=%b idle=%b overlong=%b, required reset values",
               out_valid, out_last, out_data, out_chan, in_ready, idle, overlong_err);
    end
    sync_rst = 1'b0;
  endtask

  task automatic test_random();
    int cy;
    for (int round = 0; round < 3; round++) begin
      do_reset();
      bubble_pct = 25;
      for (int ch = 0; ch < NC; ch++) begin
        int npk;
        npk = $urandom_range(0, 4);
        for (int p = 0; p < npk; p++) add_pkt(ch, $urandom_range(1, 6), '0, 1, 1, 1);
      end
      model_run(0);
      cy = 0;
      while ((exp_q.size() > 0) && cy < 2000) begin
        ready_drv = ($urandom_range(99) < 70);
        step_cycle();
        n_checks++;
        if ($countones(ob_ready) > 1) begin
          n_errors++;
          $display("FAIL rand_onehot: in_ready=%b, required one-hot or zero", ob_ready);
        end
        if (ob_valid && ready_drv) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL rand_beat: unexpected chan=%0d data=%h, required none", ob_chan, ob_data);
          end else begin
            exp_e = exp_q.pop_front();
            if ({ob_last, ob_chan, ob_data} !== exp_e) begin
              n_errors++;
              $display("FAIL rand_beat: got %b/%0d/%h, required %b/%0d/%h", ob_last, ob_chan, ob_data, exp_e[EW-1], exp_e[DW+IDW-1:DW], exp_e[DW-1:0]);
            end
          end
        end
        cy++;
      end
      ready_drv = 1'b1;
      repeat (3) step_cycle();
      n_checks++;
      if (exp_q.size() != 0 || ob_idle !== 1'b1) begin
        n_errors++;
        $display("FAIL rand_drain round %0d: left=%0d idle=%b, required 0/1", round, exp_q.size(), ob_idle);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    sync_rst = 1'b1; enable = 1'b0; in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b0;
    ready_drv = 1'b1; bubble_pct = 0;
    test_reset();
    test_single_pkt();
    test_rr_order();
    test_backpressure();
    test_enable_drop();
    test_overlong();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
